// File: rtl/booth_pkg.sv
// Shared configuration helpers for the radix-2^K Booth accumulator.
//
// Functions:
//   legal_cfg(w, k) : 1 when the operand width W is a legal multiple of the
//                     shift step K.
//   steps_of(w, k)  : number of shifts needed to retire a W-bit multiplier.
//   cnt_width(s)    : bits needed to hold a step count from 0 up to s.
package booth_pkg;

  // K must divide W exactly. K must also be smaller than W, because the
  // Q shift keeps Q[W-1:K] and that slice would be empty when K equals W.
  function automatic bit legal_cfg(input int w, input int k);
    return (k > 0) && (k < w) && ((w % k) == 0);
  endfunction

  function automatic int steps_of(input int w, input int k);
    return w / k;
  endfunction

  function automatic int cnt_width(input int steps);
    return $clog2(steps + 1);
  endfunction

endpackage

// File: rtl/booth_acc_shift_reg_if.sv
// Control and data bundle for booth_acc_shift_reg.
//
// Master (sequencer) side drives:
//   clr, ld_q, ld_a, shift   register controls
//   out_a_en, out_q_en       result bus enables
//   adder_in [W:0]           adder/subtractor result
//   inbus    [W-1:0]         multiplier operand
// Slave (register pair) side drives:
//   a_out [W:0]              current A, fed back to the adder
//   q_low [K:0]              {Q[K-1:0], Q[-1]}, the Booth recode window
//   done                     all steps of the multiplication performed
interface booth_acc_shift_reg_if #(
  parameter int W = 8,
  parameter int K = 2
) ();

  logic         clr;
  logic         ld_q;
  logic         ld_a;
  logic         shift;
  logic         out_a_en;
  logic         out_q_en;
  logic [W:0]   adder_in;
  logic [W-1:0] inbus;
  logic [W:0]   a_out;
  logic [K:0]   q_low;
  logic         done;

  modport master (
    output clr, ld_q, ld_a, shift, out_a_en, out_q_en, adder_in, inbus,
    input  a_out, q_low, done
  );

  modport slave (
    input  clr, ld_q, ld_a, shift, out_a_en, out_q_en, adder_in, inbus,
    output a_out, q_low, done
  );

endinterface

// File: rtl/booth_step_counter.sv
// Step counter for the Booth accumulator. Counts accepted shifts,
// saturates at STEPS and raises a registered done flag.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_b  in   asynchronous active-low reset
//   clr    in   synchronous clear of the count (and therefore of done)
//   inc    in   one shift was accepted this cycle
//   done   out  count has reached STEPS (registered)
module booth_step_counter
  import booth_pkg::*;
#(
  parameter int STEPS = 4
) (
  input  logic clk,
  input  logic rst_b,
  input  logic clr,
  input  logic inc,
  output logic done
);

  localparam int            CW   = cnt_width(STEPS);
  localparam logic [CW-1:0] LAST = CW'(STEPS);

  logic [CW-1:0] count_q, count_d;
  logic          done_q, done_d;

  // done is derived from the next count so that it turns on in the very
  // cycle after the final shift rather than one cycle later.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != LAST)) begin
      count_d = count_q + CW'(1);
    end
    done_d = (count_d == LAST);
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign done = done_q;

endmodule

// File: rtl/booth_acc_shift_reg.sv
// Accumulator / multiplier register pair {A, Q, Q[-1]} for a radix-2^K
// Booth multiplier. A and Q shift together as one arithmetic-right
// register by K bits per step; a step counter reports done.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst_b   in   asynchronous active-low reset
//   bus     slave modport of booth_acc_shift_reg_if (controls, operands,
//           a_out, q_low, done)
//   outbus  out  [2W:0] tri-state result bus: A on [2W:W], Q on [W-1:0],
//           each field driven only while its enable is high
module booth_acc_shift_reg
  import booth_pkg::*;
#(
  parameter int W = 8,
  parameter int K = 2
) (
  input  logic                        clk,
  input  logic                        rst_b,
  booth_acc_shift_reg_if.slave        bus,
  output wire  [2*W:0]                outbus
);

  localparam int STEPS = steps_of(W, K);

  if (!legal_cfg(W, K)) begin : g_bad_cfg
    $error("booth_acc_shift_reg: W must be a multiple of K and larger than K");
  end

  logic [W:0]   a_q, a_d;
  logic [W-1:0] q_q, q_d;
  logic         qm1_q, qm1_d;
  logic         done;
  logic         shift_en;

  logic [W:0]   a_shift;
  logic [W-1:0] q_shift;
  logic         qm1_shift;

  // Once done, a shift request is dropped completely, including the count.
  assign shift_en = bus.shift && !done;

  // Combined {A, Q, Q[-1]} arithmetic right shift by K.
  assign a_shift   = {{K{a_q[W]}}, a_q[W:K]};
  assign q_shift   = {a_q[K-1:0], q_q[W-1:K]};
  assign qm1_shift = q_q[K-1];

  // A and Q have separate priority chains: clr/ld_a only override the A
  // half of a shift and ld_q only the Q half, so the other half still
  // moves. clr also owns Q[-1] even when Q itself is shifting.
  always_comb begin
    a_d   = a_q;
    q_d   = q_q;
    qm1_d = qm1_q;

    if (bus.clr) begin
      a_d = '0;
    end else if (bus.ld_a) begin
      a_d = bus.adder_in;
    end else if (shift_en) begin
      a_d = a_shift;
    end

    if (bus.ld_q) begin
      q_d   = bus.inbus;
      qm1_d = 1'b0;
    end else if (shift_en) begin
      q_d   = q_shift;
      qm1_d = qm1_shift;
    end

    if (bus.clr) begin
      qm1_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      a_q   <= '0;
      q_q   <= '0;
      qm1_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      q_q   <= q_d;
      qm1_q <= qm1_d;
    end
  end

  booth_step_counter #(
    .STEPS (STEPS)
  ) u_step_counter (
    .clk   (clk),
    .rst_b (rst_b),
    .clr   (bus.clr),
    .inc   (shift_en),
    .done  (done)
  );

  assign bus.a_out = a_q;
  assign bus.q_low = {q_q[K-1:0], qm1_q};
  assign bus.done  = done;

  assign outbus[2*W:W]   = bus.out_a_en ? a_q : {(W+1){1'bz}};
  assign outbus[W-1:0]   = bus.out_q_en ? q_q : {W{1'bz}};

endmodule

// File: tb/tb_booth_acc_shift_reg.sv
// Directed testbench for booth_acc_shift_reg. The default W=8/K=2 instance
// covers reset, shifting, priorities and the result bus; two further
// instances (W=16/K=1, W=12/K=3) cover other step sizes and negative A.
// The result-bus nets are tri1, so an undriven (Z) field reads as all ones.
module tb_booth_acc_shift_reg;

  logic clk;
  logic rst_b;
  int   checks;
  int   failures;

  tri1 [16:0] outbus;
  tri1 [32:0] outbus16;
  tri1 [24:0] outbus12;

  booth_acc_shift_reg_if #(.W(8),  .K(2)) bus_i   ();
  booth_acc_shift_reg_if #(.W(16), .K(1)) bus16_i ();
  booth_acc_shift_reg_if #(.W(12), .K(3)) bus12_i ();

  booth_acc_shift_reg #(.W(8), .K(2)) dut (
    .clk    (clk),
    .rst_b  (rst_b),
    .bus    (bus_i),
    .outbus (outbus)
  );

  booth_acc_shift_reg #(.W(16), .K(1)) dut16 (
    .clk    (clk),
    .rst_b  (rst_b),
    .bus    (bus16_i),
    .outbus (outbus16)
  );

  booth_acc_shift_reg #(.W(12), .K(3)) dut12 (
    .clk    (clk),
    .rst_b  (rst_b),
    .bus    (bus12_i),
    .outbus (outbus12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of controls on the W=8 instance, then drop the strobes
  // one time unit after the edge.
  task automatic applyStimulus(input logic c, input logic lq, input logic la,
                               input logic sh, input logic [8:0] ain,
                               input logic [7:0] ib);
    bus_i.clr      = c;
    bus_i.ld_q     = lq;
    bus_i.ld_a     = la;
    bus_i.shift    = sh;
    bus_i.adder_in = ain;
    bus_i.inbus    = ib;
    @(posedge clk);
    #1;
    bus_i.clr   = 1'b0;
    bus_i.ld_q  = 1'b0;
    bus_i.ld_a  = 1'b0;
    bus_i.shift = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_b    = 1'b0;

    bus_i.clr = 1'b0; bus_i.ld_q = 1'b0; bus_i.ld_a = 1'b0; bus_i.shift = 1'b0;
    bus_i.out_a_en = 1'b0; bus_i.out_q_en = 1'b0;
    bus_i.adder_in = '0; bus_i.inbus = '0;
    bus16_i.clr = 1'b0; bus16_i.ld_q = 1'b0; bus16_i.ld_a = 1'b0; bus16_i.shift = 1'b0;
    bus16_i.out_a_en = 1'b0; bus16_i.out_q_en = 1'b0;
    bus16_i.adder_in = '0; bus16_i.inbus = '0;
    bus12_i.clr = 1'b0; bus12_i.ld_q = 1'b0; bus12_i.ld_a = 1'b0; bus12_i.shift = 1'b0;
    bus12_i.out_a_en = 1'b0; bus12_i.out_q_en = 1'b0;
    bus12_i.adder_in = '0; bus12_i.inbus = '0;

    // Power-on reset
    #7;
    checkOutput("rst_a_out", 64'(bus_i.a_out), 64'h0);
    checkOutput("rst_q_low", 64'(bus_i.q_low), 64'h0);
    checkOutput("rst_done", 64'(bus_i.done), 64'h0);
    checkOutput("rst_bus_idle", 64'(outbus), 64'h1FFFF);
    #5;
    rst_b = 1'b1;

    // Basic shift: A=1A5, Q=3C -> A=1E9, Q=4F, Q[-1]=0
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 9'h000, 8'h3C);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 9'h1A5, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 9'h000, 8'h00);
    checkOutput("basic_a", 64'(bus_i.a_out), 64'h1E9);
    checkOutput("basic_q_low", 64'(bus_i.q_low), 64'h6);
    bus_i.out_q_en = 1'b1;
    #1;
    checkOutput("basic_q", 64'(outbus[7:0]), 64'h4F);
    bus_i.out_q_en = 1'b0;

    // Shift with ld_q: A still shifts, Q loads, Q[-1] cleared
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 9'h000, 8'h5A);
    checkOutput("ldq_shift_a", 64'(bus_i.a_out), 64'h1FA);
    checkOutput("ldq_shift_q_low", 64'(bus_i.q_low), 64'h4);

    // clr leaves Q alone
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 8'h00);
    checkOutput("clr_a", 64'(bus_i.a_out), 64'h0);
    checkOutput("clr_q_low", 64'(bus_i.q_low), 64'h4);

    // Full run: Q=07, four shifts with ld_a=0
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 9'h000, 8'h07);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 9'h000, 8'h00);
    checkOutput("run1_q_low", 64'(bus_i.q_low), 64'h3);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 9'h000, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 9'h000, 8'h00);
    checkOutput("run3_done", 64'(bus_i.done), 64'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 9'h000, 8'h00);
    checkOutput("run4_done", 64'(bus_i.done), 64'h1);
    checkOutput("run4_a", 64'(bus_i.a_out), 64'h0);
    checkOutput("run4_q_low", 64'(bus_i.q_low), 64'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 9'h1A5, 8'h3C);
    checkOutput("done_hold_load", 64'(bus_i.done), 64'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 9'h000, 8'h00);
    checkOutput("done_shift_a", 64'(bus_i.a_out), 64'h1A5);
    checkOutput("done_shift_q_low", 64'(bus_i.q_low), 64'h0);
    checkOutput("done_shift_done", 64'(bus_i.done), 64'h1);

    // Priority: clr + ld_a + shift together
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 8'h00);
    checkOutput("prio_clr_done", 64'(bus_i.done), 64'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 9'h1A7, 8'h3C);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 9'h0FF, 8'h00);
    checkOutput("prio_a", 64'(bus_i.a_out), 64'h0);
    checkOutput("prio_q_low", 64'(bus_i.q_low), 64'h6);
    bus_i.out_q_en = 1'b1;
    #1;
    checkOutput("prio_q_bus", 64'(outbus), 64'h1FFCF);
    bus_i.out_q_en = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 9'h000, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 9'h000, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 9'h000, 8'h00);
    checkOutput("prio_run3_done", 64'(bus_i.done), 64'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 9'h000, 8'h00);
    checkOutput("prio_run4_done", 64'(bus_i.done), 64'h1);

    // Result bus fields: A=155, Q=AA
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 9'h155, 8'hAA);
    bus_i.out_a_en = 1'b1;
    #1;
    checkOutput("bus_a_only", 64'(outbus), 64'h155FF);
    bus_i.out_a_en = 1'b0;
    bus_i.out_q_en = 1'b1;
    #1;
    checkOutput("bus_q_only", 64'(outbus), 64'h1FFAA);
    bus_i.out_a_en = 1'b1;
    #1;
    checkOutput("bus_both", 64'(outbus), 64'h155AA);
    checkOutput("pre_reset_done", 64'(bus_i.done), 64'h1);

    // Mid-cycle reset with both enables on
    #1;
    rst_b = 1'b0;
    #1;
    checkOutput("midrst_bus", 64'(outbus), 64'h00000);
    checkOutput("midrst_a", 64'(bus_i.a_out), 64'h0);
    checkOutput("midrst_q_low", 64'(bus_i.q_low), 64'h0);
    checkOutput("midrst_done", 64'(bus_i.done), 64'h0);
    bus_i.out_a_en = 1'b0;
    bus_i.out_q_en = 1'b0;
    #1;
    checkOutput("midrst_bus_idle", 64'(outbus), 64'h1FFFF);
    #2;
    rst_b = 1'b1;

    // W=16, K=1: negative A, sixteen single-bit steps
    bus16_i.ld_q = 1'b1; bus16_i.inbus = 16'h8001;
    bus16_i.ld_a = 1'b1; bus16_i.adder_in = 17'h12345;
    @(posedge clk);
    #1;
    bus16_i.ld_q = 1'b0; bus16_i.ld_a = 1'b0; bus16_i.shift = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("w16_first_a", 64'(bus16_i.a_out), 64'h191A2);
    checkOutput("w16_first_q_low", 64'(bus16_i.q_low), 64'h1);
    for (int i = 1; i < 15; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("w16_15_done", 64'(bus16_i.done), 64'h0);
    @(posedge clk);
    #1;
    bus16_i.shift = 1'b0;
    checkOutput("w16_16_done", 64'(bus16_i.done), 64'h1);
    checkOutput("w16_final_a", 64'(bus16_i.a_out), 64'h1FFFF);
    checkOutput("w16_final_q_low", 64'(bus16_i.q_low), 64'h3);
    bus16_i.out_q_en = 1'b1;
    #1;
    checkOutput("w16_q_bus", 64'(outbus16), 64'h1_FFFF_2345);
    bus16_i.out_q_en = 1'b0;

    // W=12, K=3: negative A, four three-bit steps
    bus12_i.ld_q = 1'b1; bus12_i.inbus = 12'h5A3;
    bus12_i.ld_a = 1'b1; bus12_i.adder_in = 13'h1ABC;
    @(posedge clk);
    #1;
    bus12_i.ld_q = 1'b0; bus12_i.ld_a = 1'b0; bus12_i.shift = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("w12_first_a", 64'(bus12_i.a_out), 64'h1F57);
    checkOutput("w12_first_q_low", 64'(bus12_i.q_low), 64'h8);
    bus12_i.shift = 1'b0;
    bus12_i.out_q_en = 1'b1;
    #1;
    checkOutput("w12_q_bus", 64'(outbus12), 64'h1FFF8B4);
    bus12_i.out_q_en = 1'b0;
    bus12_i.shift = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checkOutput("w12_3_done", 64'(bus12_i.done), 64'h0);
    @(posedge clk);
    #1;
    bus12_i.shift = 1'b0;
    checkOutput("w12_4_done", 64'(bus12_i.done), 64'h1);
    checkOutput("w12_final_a", 64'(bus12_i.a_out), 64'h1FFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/booth_acc_shift_reg.md
Name: booth_acc_shift_reg

Overview:
- Parametrised accumulator/multiplier register pair (A, Q, Q[-1]) for the radix-2^K Booth multiplier datapath.
- Generalises the fixed 9-bit radix-4 accumulator. Width W and shift step K are parameters.
- A and Q shift as one combined arithmetic-right register. An internal step counter flags `done`.
- Independent tri-state drive of the A and Q fields onto the shared result bus.

Parameters:
- W, 8, operand width; A is W+1 bits (sign guard), Q is W bits.
- K, 2, bits shifted per step (radix 2^K); W mod K must be 0.
- STEPS, W/K, shifts per multiplication; derived, not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- rst_b  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear of A, Q[-1] and step counter (Q untouched).
- ld_q  in  1  load Q from inbus and clear Q[-1].
- ld_a  in  1  load A from adder_in.
- shift  in  1  arithmetic right shift of {A,Q,Q[-1]} by K.
- out_a_en  in  1  drive A onto outbus[2W:W].
- out_q_en  in  1  drive Q onto outbus[W-1:0].
- adder_in  in  W+1  adder/subtractor result.
- inbus  in  W  multiplier operand.
- a_out  out  W+1  current A (to adder).
- q_low  out  K+1  {Q[K-1:0], Q[-1]}, Booth recode window.
- outbus  out  2W+1  tri-state result bus.
- done  out  1  step count reached STEPS.

Behaviour:
- Reset (rst_b=0, async): A=0, Q=0, Q[-1]=0, count=0, done=0. outbus is Z unless out_*_en is asserted.
- A priority per edge: clr > ld_a > shift. Only the highest asserted takes effect.
- clr: A=0, Q[-1]=0, count=0.
- ld_a: A=adder_in. Q, Q[-1] and count are unchanged.
- Q/Q[-1] priority per edge: ld_q > shift.
  - ld_q: Q=inbus, Q[-1]=0.
  - ld_q does not touch A or count. It is legal in the same cycle as clr or ld_a.
- shift, when not done and not overridden by clr/ld_a for A, or by ld_q for Q:
  - A_new = {K copies of A[W], A[W:K]}.
  - Q_new = {A[K-1:0], Q[W-1:K]}.
  - Q[-1]_new = Q[K-1].
  - count increments by 1.
- Partial overrides:
  - shift with ld_a: A loads from adder_in, Q still shifts in the old A[K-1:0], count increments.
  - shift with ld_q: A still shifts, Q and Q[-1] load, count increments.
  - shift with clr: clr wins for A, Q[-1] and count. Q still shifts in the old A[K-1:0] (unless ld_q).
- shift while done=1: ignored entirely. No register change; count saturates at STEPS.
- done is registered: it is 1 in the cycle after the STEPS-th shift, and clears on clr or reset.
- Outputs:
  - a_out and q_low are combinational from the registers, with zero latency.
  - outbus[2W:W] = A when out_a_en, else Z.
  - outbus[W-1:0] = Q when out_q_en, else Z.
  - outbus[W-1:0] fields are independent. With both enables, the full {A,Q} (2W+1 bits) is driven.
- Reset mid-operation aborts immediately. No pending shift completes.

Decomposition:
- Package booth_pkg: W/K legality check function, STEPS derivation, count width function clog2(STEPS+1).
- Sub-module booth_step_counter:
  - Inputs: clk, rst_b, clr, inc.
  - Output: done.
  - Behaviour: saturating at STEPS.
- The shift datapath stays in the top module.

Test Plan:
- Reset: drive out_a_en=out_q_en=1, pulse rst_b low mid-cycle -> A, Q and done go to 0 immediately; outbus=17'h00000. Then release enables -> outbus all Z.
- Basic shift (W=8, K=2):
  - Setup: ld_q with inbus=8'h3C, then ld_a with adder_in=9'h1A5.
  - Stimulus: one shift.
  - Required: A=9'h1E9, Q=8'h4F, Q[-1]=0, q_low=3'b110.
- Full run: clr, ld_q=8'h07, then 4 shifts with ld_a=9'h000 -> done=1 after the 4th edge. A fifth shift leaves A, Q and count unchanged.
- Priority: clr, ld_a (adder_in=9'h0FF) and shift asserted together -> A=0, count=0, Q shifted in old A[1:0].
- Bus fields: A=9'h155, Q=8'hAA.
  - out_a_en only -> outbus[16:8]=9'h155, [7:0]=Z.
  - out_q_en only -> [7:0]=8'hAA, [16:8]=Z.
- Parameter sweep: W=16, K=1 and W=12, K=3 -> done after 16 and 4 shifts respectively. Sign extension correct for negative A.
